// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides. Shifts run either as a
// one-cycle barrel shift or one bit per cycle. Multiply is a fixed-length shift-add.
module alu_mc #(
  parameter int WIDTH      = 16,
  parameter bit FAST_SHIFT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       szcv
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] w, w_nxt;
  logic [WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [CW-1:0]    cnt;
  logic             c_nxt;
  logic             accept, iter, last_step;
  logic [WIDTH+1:0] single;

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
    return {r[WIDTH-1], (r == '0), c, v};
  endfunction

  // One-cycle result as {C, V, res}; MUL never takes this path, so it falls to the default.
  function automatic logic [WIDTH+1:0] exec_single(input logic [3:0] o,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
    logic [WIDTH:0]          wide;
    logic [WIDTH-1:0]        r;
    logic signed [WIDTH-1:0] sx;
    logic [SHW-1:0]          k;
    logic                    c, v;
    wide = '0;
    r    = '0;
    c    = 1'b0;
    v    = 1'b0;
    sx   = x;
    k    = y[SHW-1:0];
    case (o)
      4'b0000: begin
        wide = {1'b0, x} + {1'b0, y};
        r = wide[WIDTH-1:0];
        c = wide[WIDTH];
        v = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      4'b0001, 4'b0101: begin
        wide = {1'b0, x} - {1'b0, y};
        r = wide[WIDTH-1:0];
        c = wide[WIDTH];
        v = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      4'b0010: r = x & y;
      4'b0011: r = x | y;
      4'b0100: r = x ^ y;
      4'b0110: r = x;
      4'b1000: begin
        wide = {1'b0, x} << k;
        r = wide[WIDTH-1:0];
        c = wide[WIDTH];
      end
      4'b1001: begin
        wide = {1'b0, x} << k;
        r = wide[WIDTH-1:0] | (x >> (WIDTH - int'(k)));
        c = wide[WIDTH];
      end
      4'b1010: begin
        wide = {x, 1'b0} >> k;
        r = wide[WIDTH:1];
        c = wide[0];
      end
      4'b1011: begin
        wide = {x, 1'b0} >> k;
        r = sx >>> k;
        c = wide[0];
      end
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  assign out_valid = (state == DONE);
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign iter      = (op == 4'b0111) ||
                     (!FAST_SHIFT && (op[3:2] == 2'b10) && (b[SHW-1:0] != '0));
  assign single    = exec_single(op, a, b);
  assign last_step = (state == BUSY) && (cnt == CW'(1));

  // Iterative step: one shift bit, or one shift-add of the multiplier.
  always_comb begin
    w_nxt      = w;
    c_nxt      = 1'b0;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    case (op_r)
      4'b1000: begin c_nxt = w[WIDTH-1]; w_nxt = {w[WIDTH-2:0], 1'b0};       end
      4'b1001: begin c_nxt = w[WIDTH-1]; w_nxt = {w[WIDTH-2:0], w[WIDTH-1]}; end
      4'b1010: begin c_nxt = w[0];       w_nxt = {1'b0, w[WIDTH-1:1]};       end
      4'b1011: begin c_nxt = w[0];       w_nxt = {w[WIDTH-1], w[WIDTH-1:1]}; end
      default: begin
        w_nxt      = mplier[0] ? (w + mcand) : w;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = iter ? BUSY : DONE;
    end else begin
      case (state)
        BUSY:    if (last_step) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      res   <= '0;
      szcv  <= '0;
    end else begin
      state <= state_nxt;
      if (accept && !iter) begin
        res  <= single[WIDTH-1:0];
        szcv <= mk_flags(single[WIDTH-1:0], single[WIDTH+1], single[WIDTH]);
      end else if (last_step) begin
        res  <= w_nxt;
        szcv <= mk_flags(w_nxt, c_nxt, 1'b0);
      end
    end
  end

  // Operand/working registers carry no reset; they are only read in BUSY after a load.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r   <= op;
      w      <= (op == 4'b0111) ? '0 : a;
      mcand  <= a;
      mplier <= b;
      cnt    <= (op == 4'b0111) ? CW'(WIDTH) : {1'b0, b[SHW-1:0]};
    end else if (state == BUSY) begin
      w      <= w_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      cnt    <= cnt - CW'(1);
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=16, FAST_SHIFT=0): directed corner cases plus randomized
// operations scored against an arithmetic reference model.
module tb_alu_mc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] res;
  logic [3:0]  szcv;

  int n_checks = 0;
  int n_errors = 0;

  alu_mc #(.WIDTH(16), .FAST_SHIFT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .szcv(szcv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: results from integer arithmetic, flags from range/ordering rules.
  function automatic void model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] r, output logic [3:0] f, output int lat);
    int unsigned ux, uy;
    int sx, sy, k;
    logic c, v;
    ux = x; uy = y; sx = $signed(x); sy = $signed(y); k = int'(y & 16'h000f);
    c = 1'b0; v = 1'b0; lat = 1; r = 16'h0;
    case (o)
      4'd0: begin r = 16'(ux + uy); c = (ux + uy) > 65535;
                  v = (sx + sy > 32767) || (sx + sy < -32768); end
      4'd1, 4'd5: begin r = 16'(ux - uy); c = ux < uy;
                  v = (sx - sy > 32767) || (sx - sy < -32768); end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd6: r = x;
      4'd7: begin r = 16'(ux * uy); lat = 17; end
      4'd8: begin r = 16'(ux << k); c = (k != 0) && (((ux >> (16 - k)) & 1) == 1); end
      4'd9: begin r = 16'((ux << k) | (ux >> (16 - k))); c = (k != 0) && r[0]; end
      4'd10: begin r = 16'(ux >> k); c = (k != 0) && (((ux >> (k - 1)) & 1) == 1); end
      4'd11: begin r = 16'(sx >>> k); c = (k != 0) && (((ux >> (k - 1)) & 1) == 1); end
      default: r = 16'h0;
    endcase
    if (o >= 4'd8 && o <= 4'd11 && k != 0) lat = k + 1;
    f = {r[15], r == 16'h0, c, v};
  endfunction

  // Called #1 after a rising edge with the block idle; leaves it idle again.
  task automatic do_op(input string tag, input logic [3:0] o, input logic [15:0] x,
                       input logic [15:0] y, input logic [15:0] er, input logic [3:0] ef,
                       input int elat);
    int lat;
    int rdy_busy;
    rdy_busy = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_busy++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_res"}, res, er);
    check({tag, "_szcv"}, szcv, ef);
    check({tag, "_rdy_busy"}, rdy_busy, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_rand(input string tag, input logic [3:0] o, input logic [15:0] x,
                         input logic [15:0] y);
    logic [15:0] er;
    logic [3:0]  ef;
    int          el;
    model(o, x, y, er, ef, el);
    do_op(tag, o, x, y, er, ef, el);
  endtask

  initial begin
    logic [15:0] er, hold_res;
    logic [3:0]  ef, hold_f, ro;
    int          el;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 4'h0; a = 16'h0; b = 16'h0;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_res", res, 16'h0);
    check("rst_szcv", szcv, 4'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1'b1);

    do_op("add_ovf", 4'h0, 16'h7fff, 16'h0001, 16'h8000, 4'b1001, 1);
    do_op("sub_brw", 4'h1, 16'h0000, 16'h0001, 16'hffff, 4'b1010, 1);
    do_op("cmp_eq",  4'h5, 16'h1234, 16'h1234, 16'h0000, 4'b0100, 1);
    do_op("sra3",    4'hb, 16'h8001, 16'h0003, 16'hf000, 4'b1000, 4);
    do_op("sll1",    4'h8, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 2);
    do_op("mul",     4'h7, 16'h0003, 16'hffff, 16'hfffd, 4'b1000, 17);
    do_op("bad_op",  4'hd, 16'h1234, 16'h5678, 16'h0000, 4'b0100, 1);
    do_op("srl_k0",  4'ha, 16'h8001, 16'hfff0, 16'h8001, 4'b1000, 1);
    do_op("rot_hi",  4'h9, 16'h8001, 16'hff14, 16'h0018, 4'b0000, 5);

    // Backpressure: hold the result in DONE, then swap in a new ADD in the release cycle.
    op = 4'h4; a = 16'h00ff; b = 16'h0f0f; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    hold_res = res; hold_f = szcv;
    check("bp_first_res", res, 16'h0ff0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1'b1);
      check("bp_res_hold", res, hold_res);
      check("bp_szcv_hold", szcv, hold_f);
      check("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1; op = 4'h0; a = 16'h0010; b = 16'h0020; in_valid = 1'b1;
    #1 check("bp_swap_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_swap_valid", out_valid, 1'b1);
    check("bp_swap_res", res, 16'h0030);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle", out_valid, 1'b0);

    // Back-to-back single-cycle ops with out_ready held.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ro = 4'($urandom_range(0, 6));
      op = ro; a = $urandom; b = $urandom; in_valid = 1'b1;
      model(ro, a, b, er, ef, el);
      @(posedge clk); #1;
      check("b2b_valid", out_valid, 1'b1);
      check("b2b_res", res, er);
      check("b2b_szcv", szcv, ef);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_idle", out_valid, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      if (i % 3 == 0) do_rand("rnd", ro, $urandom, 16'($urandom_range(0, 15)));
      else            do_rand("rnd", ro, $urandom, $urandom);
    end

    // Reset in the middle of a multiply abandons it.
    op = 4'h7; a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_res", res, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("post_rst_valid", out_valid, 1'b0);
    do_op("post_rst_add", 4'h0, 16'h0001, 16'h0001, 16'h0002, 4'b0000, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
